// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: groups the button/tick inputs and the time/mode/blink outputs of clock_set_ctrl.
//   tick_1hz, btn_mode, btn_inc : enable tick and debounced button levels into the controller
//   hours, minutes, seconds     : current time (0..23, 0..59, 0..59)
//   mode, blink                 : 00 RUN / 01 SET_HR / 10 SET_MIN, and visible phase of the edited field
interface clock_set_ctrl_if;
   logic       tick_1hz;
   logic       btn_mode;
   logic       btn_inc;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [1:0] mode;
   logic       blink;
   modport master (output tick_1hz, btn_mode, btn_inc, input hours, minutes, seconds, mode, blink);
   modport slave  (input tick_1hz, btn_mode, btn_inc, output hours, minutes, seconds, mode, blink);
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: HH:MM:SS timekeeping with a RUN -> SET_HR -> SET_MIN -> RUN time-set FSM.
//   clk_in : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io     : slave side of clock_set_ctrl_if (tick/buttons in, time/mode/blink out)
module clock_set_ctrl #(
   parameter int TIMEOUT_TICKS = 10,
   parameter int SYNC_STAGES   = 2
) (
   input  logic            clk_in,
   input  logic            rst_n,
   clock_set_ctrl_if.slave io
);
   typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10, BAD = 2'b11} state_t;
   localparam int TW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
   logic [SYNC_STAGES-1:0] mode_sync, inc_sync;
   logic                   mode_d, inc_d, mode_edge, inc_edge, timeout;
   state_t                 state, state_n;
   logic [4:0]             hours, hours_n;
   logic [5:0]             minutes, minutes_n, seconds, seconds_n;
   logic                   blink, blink_n;
   logic [TW-1:0]          to_cnt, to_cnt_n;
   assign mode_edge = mode_sync[SYNC_STAGES-1] & ~mode_d;
   assign inc_edge  = inc_sync[SYNC_STAGES-1] & ~inc_d;
   // Fires on the tick that would bring the idle count up to TIMEOUT_TICKS.
   assign timeout   = (TIMEOUT_TICKS != 0) && io.tick_1hz && (to_cnt + TW'(1) == TW'(TIMEOUT_TICKS));
   always_comb begin
      state_n   = state;
      hours_n   = hours;
      minutes_n = minutes;
      seconds_n = seconds;
      blink_n   = blink;
      to_cnt_n  = to_cnt;
      case (state)
         RUN: begin
            blink_n  = 1'b0;
            to_cnt_n = '0;
            if (io.tick_1hz) begin
               seconds_n = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
               if (seconds == 6'd59) begin
                  minutes_n = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                  if (minutes == 6'd59) hours_n = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
               end
            end
            if (mode_edge) begin
               state_n = SET_HR;
               blink_n = 1'b1;
            end
         end
         SET_HR, SET_MIN: begin
            if (io.tick_1hz) begin
               blink_n  = ~blink;
               to_cnt_n = to_cnt + TW'(1);
            end
            // Mode beats inc, and any button edge beats the timeout.
            if (mode_edge) begin
               state_n  = (state == SET_HR) ? SET_MIN : RUN;
               blink_n  = (state == SET_HR);
               to_cnt_n = '0;
               if (state == SET_MIN) seconds_n = 6'd0;
            end else if (inc_edge) begin
               to_cnt_n = '0;
               if (state == SET_HR) hours_n = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
               else minutes_n = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            end else if (timeout) begin
               state_n   = RUN;
               blink_n   = 1'b0;
               to_cnt_n  = '0;
               seconds_n = 6'd0;
            end
         end
         default: begin
            state_n  = RUN;
            blink_n  = 1'b0;
            to_cnt_n = '0;
         end
      endcase
   end
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         mode_sync <= '0;
         inc_sync  <= '0;
         mode_d    <= 1'b0;
         inc_d     <= 1'b0;
         state     <= RUN;
         hours     <= '0;
         minutes   <= '0;
         seconds   <= '0;
         blink     <= 1'b0;
         to_cnt    <= '0;
      end else begin
         mode_sync <= {mode_sync[SYNC_STAGES-2:0], io.btn_mode};
         inc_sync  <= {inc_sync[SYNC_STAGES-2:0], io.btn_inc};
         mode_d    <= mode_sync[SYNC_STAGES-1];
         inc_d     <= inc_sync[SYNC_STAGES-1];
         state     <= state_n;
         hours     <= hours_n;
         minutes   <= minutes_n;
         seconds   <= seconds_n;
         blink     <= blink_n;
         to_cnt    <= to_cnt_n;
      end
   end
   assign io.hours   = hours;
   assign io.minutes = minutes;
   assign io.seconds = seconds;
   assign io.mode    = state;
   assign io.blink   = blink;
endmodule
